divmod_rr_sched: RTL and testbench

- Round-robin scheduler that shares one fixed-latency, non-stallable divide/modulo pipeline among NUM_REQ requesters.
- Accepts at most one operation per cycle, drives the pipeline's operand inputs and tracks each op in a tag shift register.
- Returns quotient/remainder on a shared response bus, tagged with the requester id.
- Handles divide-by-zero locally, because the shared unit's output is undefined for in2 == 0.

---
 rtl/divmod_rr_sched.sv | 158 +++++++++++++++
 tb/tb_divmod_rr_sched.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divmod_rr_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : divmod_rr_sched                                                  |
// | Brief   : Round-robin issue of NUM_REQ requesters into one shared,         |
// |           fixed-latency divide/modulo pipeline; tagged, in-order replies.  |
// |           Define DIVMOD_RR_SCHED_STATS_EN to add the stat_* counters.      |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module divmod_rr_sched #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 4,
  parameter int NUM_REQ = 4,
  localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_in1,
  input  logic [NUM_REQ*WIDTH-1:0] req_in2,
  output logic [WIDTH-1:0]         dm_in1,
  output logic [WIDTH-1:0]         dm_in2,
  input  logic [WIDTH-1:0]         dm_div,
  input  logic [WIDTH-1:0]         dm_mod,
  output logic                     rsp_valid,
  output logic [IDW-1:0]           rsp_id,
  output logic [WIDTH-1:0]         rsp_div,
  output logic [WIDTH-1:0]         rsp_mod,
  output logic                     rsp_dz
`ifdef DIVMOD_RR_SCHED_STATS_EN
  ,
  output logic [31:0]              stat_ops,
  output logic [31:0]              stat_dz,
  output logic [31:0]              stat_conflict
`endif
);

  localparam logic [IDW:0] c_nreq = (IDW+1)'(NUM_REQ);

  logic [IDW-1:0]   r_ptr;
  logic [NUM_REQ-1:0] w_rot;
  logic             w_found;
  logic [IDW-1:0]   w_off;
  logic [IDW:0]     w_sum;
  logic [IDW-1:0]   w_gid;
  logic             w_xfer;
  logic             w_dz;
  logic [WIDTH-1:0] w_g_in1;
  logic [WIDTH-1:0] w_g_in2;

  logic             r_tv   [LATENCY];
  logic [IDW-1:0]   r_tid  [LATENCY];
  logic             r_tdz  [LATENCY];
  logic [WIDTH-1:0] r_tin1 [LATENCY];

  // Rotate so the pointer lands on bit 0; the lowest set bit is then the winner.
  assign w_rot = NUM_REQ'({req_valid, req_valid} >> r_ptr);

  always_comb begin
    w_found = 1'b0;
    w_off   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_found = 1'b1;
        w_off   = IDW'(k);
      end
    end
  end

  assign w_sum  = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_gid  = (w_sum >= c_nreq) ? IDW'(w_sum - c_nreq) : IDW'(w_sum);
  assign w_xfer = w_found && !reset;

  always_comb begin
    req_ready = '0;
    if (w_xfer) req_ready = NUM_REQ'(1) << w_gid;
  end

  always_comb begin
    w_g_in1 = '0;
    w_g_in2 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gid == IDW'(i)) begin
        w_g_in1 = req_in1[i*WIDTH +: WIDTH];
        w_g_in2 = req_in2[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_dz = (w_g_in2 == '0);

  // The divider is never fed X or zero: idle cycles and zero divisors present 1.
  assign dm_in1 = w_xfer ? w_g_in1 : '0;
  assign dm_in2 = (w_xfer && !w_dz) ? w_g_in2 : WIDTH'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (w_xfer) begin
      r_ptr <= (w_gid == IDW'(NUM_REQ - 1)) ? '0 : w_gid + IDW'(1);
    end
  end

  always_ff @(posedge clock) begin
    r_tv[0]   <= reset ? 1'b0 : w_xfer;
    r_tid[0]  <= w_gid;
    r_tdz[0]  <= w_dz;
    r_tin1[0] <= w_g_in1;
    for (int k = 1; k < LATENCY; k++) begin
      r_tv[k]   <= reset ? 1'b0 : r_tv[k-1];
      r_tid[k]  <= r_tid[k-1];
      r_tdz[k]  <= r_tdz[k-1];
      r_tin1[k] <= r_tin1[k-1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_div   <= '0;
      rsp_mod   <= '0;
      rsp_dz    <= 1'b0;
    end else begin
      rsp_valid <= r_tv[LATENCY-1];
      rsp_dz    <= r_tv[LATENCY-1] && r_tdz[LATENCY-1];
      if (r_tv[LATENCY-1]) begin
        rsp_id <= r_tid[LATENCY-1];
        if (r_tdz[LATENCY-1]) begin
          rsp_div <= '1;
          rsp_mod <= r_tin1[LATENCY-1];
        end else begin
          rsp_div <= dm_div;
          rsp_mod <= dm_mod;
        end
      end
    end
  end

`ifdef DIVMOD_RR_SCHED_STATS_EN
  logic w_multi;
  assign w_multi = |(req_valid & (req_valid - NUM_REQ'(1)));

  always_ff @(posedge clock) begin
    if (reset) begin
      stat_ops      <= '0;
      stat_dz       <= '0;
      stat_conflict <= '0;
    end else begin
      if (w_xfer && stat_ops != '1)         stat_ops      <= stat_ops + 32'd1;
      if (w_xfer && w_dz && stat_dz != '1)  stat_dz       <= stat_dz + 32'd1;
      if (w_multi && stat_conflict != '1)   stat_conflict <= stat_conflict + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_divmod_rr_sched.sv
`default_nettype none
// Bench for divmod_rr_sched: shared-divider stand-in, queue-based reference
// model checked every cycle, plus directed literal expectations.
module tb_divmod_rr_sched;
  localparam int W   = 32;
  localparam int L   = 4;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_in1 = '0;
  logic [N*W-1:0] req_in2 = '0;
  logic [W-1:0]   dm_in1, dm_in2, dm_div, dm_mod;
  logic           rsp_valid, rsp_dz;
  logic [IDW-1:0] rsp_id;
  logic [W-1:0]   rsp_div, rsp_mod;
`ifdef DIVMOD_RR_SCHED_STATS_EN
  logic [31:0]    stat_ops, stat_dz, stat_conflict;
`endif

  divmod_rr_sched #(.WIDTH(W), .LATENCY(L), .NUM_REQ(N)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_in1(req_in1), .req_in2(req_in2),
    .dm_in1(dm_in1), .dm_in2(dm_in2), .dm_div(dm_div), .dm_mod(dm_mod),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_div(rsp_div),
    .rsp_mod(rsp_mod), .rsp_dz(rsp_dz)
`ifdef DIVMOD_RR_SCHED_STATS_EN
    , .stat_ops(stat_ops), .stat_dz(stat_dz), .stat_conflict(stat_conflict)
`endif
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Shared divmod unit: L-deep, no enable, not reset.
  logic [W-1:0] sa [L];
  logic [W-1:0] sb [L];
  always @(posedge clock) begin
    sa[0] <= dm_in1;
    sb[0] <= dm_in2;
    for (int k = 1; k < L; k++) begin
      sa[k] <= sa[k-1];
      sb[k] <= sb[k-1];
    end
  end
  assign dm_div = (sb[L-1] == '0) ? 32'hDEADBEEF : sa[L-1] / sb[L-1];
  assign dm_mod = (sb[L-1] == '0) ? 32'hDEADBEEF : sa[L-1] % sb[L-1];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int           due;
    int           id;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } exp_t;

  exp_t         q[$];
  int           mptr = 0;
  bit           chk_rsp = 0;
  int           n_rsp = 0;
  logic [W-1:0] h_id = '0, h_div = '0, h_mod = '0;

  function automatic int model_grant(input int p, input logic [N-1:0] v);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  always @(negedge clock) begin
    exp_t         e;
    int           g;
    logic [W-1:0] a, b;
    logic [N-1:0] er;
    if (rsp_valid === 1'b1) n_rsp++;
    if (chk_rsp) begin
      if (q.size() != 0 && q[0].due == cyc) begin
        e     = q.pop_front();
        h_id  = W'(e.id);
        h_div = (e.b == '0) ? '1  : e.a / e.b;
        h_mod = (e.b == '0) ? e.a : e.a % e.b;
        chk("rsp_valid", 64'(rsp_valid), 64'(1));
        chk("rsp_dz", 64'(rsp_dz), 64'(e.b == '0));
      end else begin
        chk("rsp_valid_idle", 64'(rsp_valid), 64'(0));
        chk("rsp_dz_idle", 64'(rsp_dz), 64'(0));
      end
      chk("rsp_id", 64'(rsp_id), 64'(h_id));
      chk("rsp_div", 64'(rsp_div), 64'(h_div));
      chk("rsp_mod", 64'(rsp_mod), 64'(h_mod));
    end
    g  = reset ? -1 : model_grant(mptr, req_valid);
    er = '0;
    a  = '0;
    b  = 32'd1;
    if (g >= 0) begin
      er = N'(1) << g;
      a  = req_in1[g*W +: W];
      b  = req_in2[g*W +: W];
    end
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("dm_in1", 64'(dm_in1), 64'(a));
    chk("dm_in2", 64'(dm_in2), 64'((b == '0) ? 32'd1 : b));
    if (reset) begin
      q.delete();
      mptr    = 0;
      h_id    = '0;
      h_div   = '0;
      h_mod   = '0;
      chk_rsp = 1;
    end else if (g >= 0) begin
      e.due = cyc + L + 1;
      e.id  = g;
      e.a   = a;
      e.b   = b;
      q.push_back(e);
      mptr = (g + 1) % N;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid[i]       = 1'b1;
    req_in1[i*W +: W]  = a;
    req_in2[i*W +: W]  = b;
  endtask

  task automatic do_reset(input int n);
    step();
    req_valid = '0;
    reset = 1'b1;
    repeat (n) step();
    reset = 1'b0;
  endtask

  task automatic issue1(input int id, input logic [W-1:0] a, input logic [W-1:0] b, output int t);
    step();
    req_valid = '0;
    set_op(id, a, b);
    t = cyc;
    #1;
    chk("lit_ready_single", 64'(req_ready), 64'(N'(1) << id));
    chk("lit_dm_in2", 64'(dm_in2), 64'((b == '0) ? 32'd1 : b));
    step();
    req_valid = '0;
  endtask

  task automatic wait_rsp(input int t, input int id, input logic [W-1:0] qd,
                          input logic [W-1:0] rm, input logic dz);
    int seen;
    seen = -1;
    for (int n = 0; n < 20 && seen < 0; n++) begin
      @(negedge clock);
      if (rsp_valid === 1'b1) seen = cyc;
    end
    chk("lit_latency", 64'(seen - t), 64'(L + 1));
    chk("lit_rsp_id", 64'(rsp_id), 64'(id));
    chk("lit_rsp_div", 64'(rsp_div), 64'(qd));
    chk("lit_rsp_mod", 64'(rsp_mod), 64'(rm));
    chk("lit_rsp_dz", 64'(rsp_dz), 64'(dz));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int t;
    int cnt [N];
    int base;
    do_reset(2);

    // single op from requester 1
    issue1(1, 32'd100, 32'd7, t);
    wait_rsp(t, 1, 32'd14, 32'd2, 1'b0);
    repeat (3) step();

    // all requesters valid: grants rotate 0,1,2,3,...
    do_reset(2);
    for (int i = 0; i < N; i++) cnt[i] = 0;
    base = n_rsp;
    for (int k = 0; k < 8; k++) begin
      step();
      for (int i = 0; i < N; i++)
        set_op(i, 32'(1000 + 97*i + 31*cnt[i]), 32'(i + 2 + cnt[i]));
      #1;
      chk("lit_ready_rotate", 64'(req_ready), 64'(N'(1) << (k % N)));
      cnt[k % N]++;
    end
    step();
    req_valid = '0;
    repeat (10) step();
    chk("lit_rotate_count", 64'(n_rsp - base), 64'(8));

    // divide by zero from requester 2
    issue1(2, 32'd55, 32'd0, t);
    wait_rsp(t, 2, 32'hFFFFFFFF, 32'd55, 1'b1);
    repeat (3) step();

    // pointer wrap: serve 0, then 3 alone, then 0 wins over 3
    issue1(0, 32'd9, 32'd4, t);
    req_valid = '0;
    set_op(3, 32'd77, 32'd10);
    #1;
    chk("lit_ready_wrap3", 64'(req_ready), 64'(4'b1000));
    step();
    req_valid = '0;
    set_op(0, 32'd81, 32'd9);
    set_op(3, 32'd88, 32'd3);
    #1;
    chk("lit_ready_after_wrap", 64'(req_ready), 64'(4'b0001));
    step();
    req_valid[0] = 1'b0;
    #1;
    chk("lit_ready_3_next", 64'(req_ready), 64'(4'b1000));
    step();
    req_valid = '0;
    repeat (8) step();

    // reset with three ops in flight
    base = n_rsp;
    issue1(0, 32'd40, 32'd3, t);
    req_valid = '0;
    set_op(1, 32'd41, 32'd5);
    step();
    req_valid = '0;
    set_op(2, 32'd42, 32'd6);
    step();
    req_valid = '0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (10) step();
    chk("lit_flush_no_rsp", 64'(n_rsp - base), 64'(0));
    base = n_rsp;
    set_op(0, 32'd123, 32'd10);
    set_op(3, 32'd200, 32'd7);
    #1;
    chk("lit_ptr_restart", 64'(req_ready), 64'(4'b0001));
    step();
    req_valid[0] = 1'b0;
    step();
    req_valid = '0;
    repeat (8) step();
    chk("lit_post_reset_rsp", 64'(n_rsp - base), 64'(2));

`ifdef DIVMOD_RR_SCHED_STATS_EN
    do_reset(2);
    issue1(0, 32'd10, 32'd3, t);
    issue1(1, 32'd20, 32'd0, t);
    issue1(2, 32'd30, 32'd4, t);
    issue1(3, 32'd40, 32'd5, t);
    step();
    set_op(0, 32'd50, 32'd6);
    set_op(1, 32'd60, 32'd7);
    step();
    set_op(0, 32'd70, 32'd8);
    step();
    req_valid[1] = 1'b0;
    set_op(2, 32'd80, 32'd0);
    step();
    req_valid[2] = 1'b0;
    step();
    req_valid = '0;
    issue1(3, 32'd90, 32'd9, t);
    issue1(1, 32'd11, 32'd2, t);
    repeat (8) step();
    chk("stat_ops", 64'(stat_ops), 64'(10));
    chk("stat_dz", 64'(stat_dz), 64'(2));
    chk("stat_conflict", 64'(stat_conflict), 64'(3));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
